ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter UNROLL, default 1, quotient/product bits resolved per cycle; legal values 1, 2, 4; WIDTH mod UNROLL SHALL be 0.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  request held high by the EX stage until success_o is seen.
REQ-006 op_i  in  1  0 = multiply, 1 = divide; sampled with start_i.
REQ-007 signed_i  in  1  1 = two's-complement operands; sampled with start_i.
REQ-008 opa_i  in  WIDTH  multiplicand or dividend.
REQ-009 opb_i  in  WIDTH  multiplier or divisor.
REQ-010 annul_i  in  1  flush from exception or branch; aborts any operation.
REQ-011 result_o  out  2*WIDTH  {HI, LO}: multiply = {high, low} product; divide = {remainder, quotient}.
REQ-012 success_o  out  1  result_o valid.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 div_zero_o  out  1  divide with opb = 0, valid with success_o.

Function
REQ-015 FSM states SHALL be IDLE, PREP, CALC, FIX, DONE.
REQ-016 IDLE: start_i=1 and annul_i=0 captures op, signed, operands, then goes to PREP.
REQ-017 PREP: convert operands to magnitudes when signed; record result signs; clear accumulator; load iteration counter with N = WIDTH/UNROLL.
REQ-018 PREP, divide with opb = 0: go directly to DONE with result_o = 0 and div_zero_o = 1.
REQ-019 CALC: each cycle, UNROLL restoring-divide or shift-add-multiply steps; decrement counter; go to FIX when counter reaches 1.
REQ-020 FIX: negate product when signs differ; negate quotient when dividend and divisor signs differ; give the remainder the sign of the dividend.
REQ-021 Signed divide of the most-negative value by -1 SHALL give quotient = most-negative value and remainder = 0, with no flag.
REQ-022 Latency: start sampled at edge k; success_o SHALL be high from edge k+N+3 (div-by-zero: k+2).
REQ-023 DONE: success_o=1 and result_o stable while start_i=1; start_i=0 returns to IDLE on the next edge with success_o=0.
REQ-024 annul_i=1 in any state SHALL force IDLE on the next edge with success_o=0; it has priority over start_i.
REQ-025 Operand inputs SHALL be ignored outside IDLE; changes mid-operation SHALL not affect the result.
REQ-026 In DONE, a new operation SHALL not start until start_i has been low for at least one cycle.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, including mid-operation; result_o=0, success_o=0, busy_o=0, div_zero_o=0, counter=0.
REQ-028 The first operation after reset release SHALL meet the REQ-022 latency.

Structure
REQ-029 FSM state encoding and the op_i codes (MD_MUL, MD_DIV) SHALL live in the shared defines package.
REQ-030 One sub-module, md_step, SHALL be combinational: a single divide/multiply step; UNROLL copies are chained by generate.
REQ-031 The EX stage SHALL map result_o to {HI_data, LO_data} and success_o to its success input.

Verification
REQ-032 WIDTH=32, UNROLL=1, unsigned div 100/7 -> success at k+35, result_o={2, 14}, div_zero_o=0.
REQ-033 Signed div -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/-1 -> {0, 0x80000000}.
REQ-034 Signed mult 0xFFFFFFFF*0xFFFFFFFF -> 0x0000000000000001; unsigned -> 0xFFFFFFFE00000001.
REQ-035 Div 5/0 -> success at k+2, result_o=0, div_zero_o=1.
REQ-036 annul_i pulse at CALC cycle 10 -> IDLE next edge, success_o never high; then a new mult 3*4 -> {0, 12}.
REQ-037 WIDTH=16, UNROLL=4, random 10k ops vs model -> all match; success at k+7; rst low mid-CALC -> all outputs 0 at once.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the ex_muldiv iterative multiply/divide unit:
// FSM state encoding and operation codes.
package ex_muldiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_CALC = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } md_state_e;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_e;

endpackage

// File: rtl/ex_muldiv_step.sv
// md_step: one combinational iteration on the {HI,LO} accumulator, either a
// restoring-divide step or a shift-add-multiply step on unsigned magnitudes.
module md_step
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_e               i_op,
   input  logic [2*WIDTH-1:0]   i_acc,
   input  logic [WIDTH-1:0]     i_b,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;
   logic [WIDTH:0] w_sum;

   always_comb begin
      // Divide: HI is the partial remainder, LO shifts the dividend out and
      // the quotient in. Bit WIDTH of the difference is the borrow.
      w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
      w_diff   = w_rem_sh - {1'b0, i_b};
      // Multiply: LO holds the unconsumed multiplier bits, HI the partial sum.
      w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
      o_acc    = i_acc;
      if (i_op == MD_DIV) begin
         if (!w_diff[WIDTH]) begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
         end else begin
            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage; result_o maps to
// {HI, LO}. UNROLL chained md_step slices resolve that many bits per CALC cycle.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 op_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opa_i,
   input  logic [WIDTH-1:0]     opb_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 success_o,
   output logic                 busy_o,
   output logic                 div_zero_o
);

   // state | meaning
   // IDLE  | waiting for start_i; captures op, signedness and operands
   // PREP  | operands to magnitudes, record result signs, load counter
   // CALC  | UNROLL md_step iterations per cycle until counter hits 1
   // FIX   | apply quotient/product and remainder signs
   // DONE  | result valid; held until start_i drops

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);

   md_state_e            r_state;
   md_state_e            w_state_nxt;
   md_op_e               r_op;
   logic                 r_signed;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg_lo;
   logic                 r_neg_hi;
   logic                 r_div_zero;

   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH-1:0]     w_hi_fix;
   logic [WIDTH-1:0]     w_lo_fix;
   logic [2*WIDTH-1:0]   w_fix;
   logic [2*WIDTH-1:0]   w_chain [UNROLL+1];

   assign w_chain[0] = r_acc;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      md_step #(.WIDTH(WIDTH)) u_step (
         .i_op  (r_op),
         .i_acc (w_chain[g]),
         .i_b   (r_b),
         .o_acc (w_chain[g+1])
      );
   end

   // Magnitude of the most-negative value wraps to itself, which is the
   // correct unsigned magnitude, so MIN/-1 needs no special case.
   assign w_a_neg  = r_signed & r_a[WIDTH-1];
   assign w_b_neg  = r_signed & r_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -r_a : r_a;
   assign w_b_mag  = w_b_neg ? -r_b : r_b;
   assign w_hi_fix = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_lo_fix = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   always_comb begin
      w_fix = r_acc;
      if (r_op == MD_MUL) begin
         w_fix = r_neg_lo ? -r_acc : r_acc;
      end else begin
         w_fix = {w_hi_fix, w_lo_fix};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      success_o   = 1'b0;
      busy_o      = 1'b1;
      div_zero_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) w_state_nxt = ST_PREP;
         end
         ST_PREP: begin
            w_state_nxt = (r_op == MD_DIV && r_b == '0) ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (r_cnt == CW'(1)) w_state_nxt = ST_FIX;
         end
         ST_FIX: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            success_o  = 1'b1;
            div_zero_o = r_div_zero;
            if (!start_i) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (annul_i) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op       <= MD_MUL;
         r_signed   <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_neg_lo   <= 1'b0;
         r_neg_hi   <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i && !annul_i) begin
                  r_op       <= md_op_e'(op_i);
                  r_signed   <= signed_i;
                  r_a        <= opa_i;
                  r_b        <= opb_i;
                  r_div_zero <= 1'b0;
               end
            end
            ST_PREP: begin
               r_neg_lo <= w_a_neg ^ w_b_neg;
               r_neg_hi <= (r_op == MD_DIV) & w_a_neg;
               r_cnt    <= CW'(N);
               r_b      <= w_b_mag;
               if (r_op == MD_DIV && r_b == '0) begin
                  r_acc      <= '0;
                  r_div_zero <= 1'b1;
               end else begin
                  r_acc <= {{WIDTH{1'b0}}, w_a_mag};
               end
            end
            ST_CALC: begin
               r_acc <= w_chain[UNROLL];
               r_cnt <= r_cnt - CW'(1);
            end
            ST_FIX: begin
               r_acc <= w_fix;
            end
            default: begin
            end
         endcase
      end
   end

   assign result_o = r_acc;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases on a 32-bit/UNROLL=1 instance,
// randomized cases against an arithmetic reference on a 16-bit/UNROLL=4 instance.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        st32 = 0, op32 = 0, sg32 = 0, an32 = 0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [63:0] res32;
   logic        succ32, busy32, dz32;

   logic        st16 = 0, op16 = 0, sg16 = 0, an16 = 0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] res16;
   logic        succ16, busy16, dz16;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_muldiv #(.WIDTH(32), .UNROLL(1)) u_dut32 (
      .clk(clk), .rst(rst), .start_i(st32), .op_i(op32), .signed_i(sg32),
      .opa_i(a32), .opb_i(b32), .annul_i(an32), .result_o(res32),
      .success_o(succ32), .busy_o(busy32), .div_zero_o(dz32)
   );

   ex_muldiv #(.WIDTH(16), .UNROLL(4)) u_dut16 (
      .clk(clk), .rst(rst), .start_i(st16), .op_i(op16), .signed_i(sg16),
      .opa_i(a16), .opb_i(b16), .annul_i(an16), .result_o(res16),
      .success_o(succ16), .busy_o(busy16), .div_zero_o(dz16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, C-style truncating division.
   function automatic logic [63:0] model(input int w, input bit op, input bit sg,
                                         input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] m, p;
      m  = (64'd1 << w) - 64'd1;
      sa = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
      if (!op) begin
         p = $unsigned(sa) * $unsigned(sb);
         return (w == 32) ? p : (p & 64'h0000_0000_FFFF_FFFF);
      end
      if (sb == 0) return 64'd0;
      q = sa / sb;
      r = sa % sb;
      return (($unsigned(r) & m) << w) | ($unsigned(q) & m);
   endfunction

   task automatic drive(input int w, input bit st, input bit op, input bit sg,
                        input logic [31:0] a, input logic [31:0] b);
      if (w == 32) begin
         st32 = st; op32 = op; sg32 = sg; a32 = a; b32 = b;
      end else begin
         st16 = st; op16 = op; sg16 = sg; a16 = a[15:0]; b16 = b[15:0];
      end
   endtask

   function automatic bit get_succ(input int w);
      return (w == 32) ? succ32 : succ16;
   endfunction

   function automatic bit get_busy(input int w);
      return (w == 32) ? busy32 : busy16;
   endfunction

   function automatic bit get_dz(input int w);
      return (w == 32) ? dz32 : dz16;
   endfunction

   function automatic logic [63:0] get_res(input int w);
      return (w == 32) ? res32 : {32'd0, res16};
   endfunction

   // Start at edge k (drive just after it); success expected from edge k+N+3.
   task automatic do_op(input int w, input bit op, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input string tag);
      int cnt, lat;
      bit got, dz_exp;
      dz_exp = op && (b == 32'd0);
      lat    = dz_exp ? 2 : ((w == 32) ? 35 : 7);
      @(posedge clk); #1;
      drive(w, 1, op, sg, a, b);
      cnt = 0;
      got = 0;
      while (!got && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 3) drive(w, 1, op, sg, $urandom, $urandom);
         if (get_succ(w)) got = 1;
      end
      check({tag, " latency"}, 64'(cnt), 64'(lat));
      check({tag, " result"}, get_res(w), exp);
      check({tag, " div_zero"}, 64'(get_dz(w)), 64'(dz_exp));
      @(posedge clk); #1;
      check({tag, " hold"}, {get_res(w)[62:0], get_succ(w)}, {exp[62:0], 1'b1});
      drive(w, 0, op, sg, a, b);
      @(posedge clk); #1;
      check({tag, " release"}, {62'd0, get_succ(w), get_busy(w)}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      logic [31:0] ra, rb;
      bit rop, rsg;

      #1;
      check("reset res32", res32, 64'd0);
      check("reset flags32", {61'd0, succ32, busy32, dz32}, 64'd0);
      check("reset res16", {32'd0, res16}, 64'd0);
      #23 rst = 1'b1;

      do_op(32, 1, 0, 32'd100, 32'd7, {32'd2, 32'd14}, "udiv 100/7");
      do_op(32, 1, 1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv -7/2");
      do_op(32, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "sdiv min/-1");
      do_op(32, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "smul -1*-1");
      do_op(32, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umul max*max");
      do_op(32, 1, 0, 32'd5, 32'd0, 64'd0, "div 5/0");
      do_op(32, 1, 1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "sdiv 7/-2");

      // Annul in the middle of CALC, then a fresh multiply.
      hits = 0;
      @(posedge clk); #1;
      drive(32, 1, 0, 0, 32'd1234, 32'd5678);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         hits += int'(succ32);
      end
      an32 = 1'b1;
      drive(32, 0, 0, 0, 32'd0, 32'd0);
      @(posedge clk); #1;
      an32 = 1'b0;
      check("annul idle", {62'd0, succ32, busy32}, 64'd0);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         hits += int'(succ32);
      end
      check("annul no success", 64'(hits), 64'd0);
      do_op(32, 0, 0, 32'd3, 32'd4, 64'd12, "mul 3*4 after annul");

      for (int i = 0; i < 150; i++) begin
         rop = 1'($urandom); rsg = 1'($urandom);
         ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
         do_op(32, rop, rsg, ra, rb, model(32, rop, rsg, ra, rb), "rand32");
      end

      for (int i = 0; i < 2000; i++) begin
         rop = 1'($urandom); rsg = 1'($urandom);
         ra = {16'd0, 16'($urandom)};
         rb = {16'd0, 16'($urandom)};
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h0000_8000; rb = 32'h0000_FFFF; end
            2: rb = $urandom_range(1, 9);
            default: ;
         endcase
         do_op(16, rop, rsg, ra, rb, model(16, rop, rsg, ra, rb), "rand16");
      end

      // Asynchronous reset while in CALC clears everything immediately.
      @(posedge clk); #1;
      drive(16, 1, 1, 0, 32'd999, 32'd7);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst mid-calc res", {32'd0, res16}, 64'd0);
      check("rst mid-calc flags", {61'd0, succ16, busy16, dz16}, 64'd0);
      drive(16, 0, 0, 0, 32'd0, 32'd0);
      #10 rst = 1'b1;
      do_op(16, 0, 1, 32'h0000_FFFD, 32'd5, model(16, 0, 1, 32'h0000_FFFD, 32'd5), "after reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
